// File: rtl/mipi_dphy_tx_burst_seq_if.sv
// Lane-parallel byte stream from the packetiser into the D-PHY TX sequencer.
// One beat carries one byte per data lane.
interface mipi_dphy_tx_burst_seq_if #(
   parameter int LANES = 4
);
   logic [8*LANES-1:0] s_data;
   logic               s_valid;
   logic               s_last;
   logic               s_ready;

   modport master (
      output s_data, s_valid, s_last,
      input  s_ready
   );

   modport slave (
      input  s_data, s_valid, s_last,
      output s_ready
   );
endinterface

// File: rtl/mipi_dphy_tx_burst_seq.sv
// D-PHY TX burst sequencer: LP-11 -> LP-01 -> LP-00 -> HS-zero -> sync
// -> payload -> trailer -> LP-11 for one clock lane and LANES data lanes.
module mipi_dphy_tx_burst_seq #(
   parameter int LANES      = 4,
   parameter int T_LPX      = 4,
   parameter int T_PREP     = 4,
   parameter int T_ZERO     = 10,
   parameter int T_CLK_PRE  = 4,
   parameter int T_TRAIL    = 6,
   parameter int T_CLK_POST = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   mipi_dphy_tx_burst_seq_if.slave s,
   output logic                   busy,
   output logic                   underrun,
   output logic                   clk_lp_p_out,
   output logic                   clk_lp_n_out,
   output logic                   clk_lp_oe,
   output logic                   clk_hs_oe,
   output logic                   clk_hs_run,
   output logic [8*LANES-1:0]     d_hs_out,
   output logic                   d_hs_oe,
   output logic [LANES-1:0]       d_lp_p_out,
   output logic [LANES-1:0]       d_lp_n_out,
   output logic [LANES-1:0]       d_lp_oe
);
   typedef enum logic [3:0] {
      IDLE, C_LP01, C_LP00, C_ZERO, C_PRE,
      D_LP01, D_LP00, D_ZERO, D_SYNC, PAYLOAD,
      D_TRAIL, D_EXIT, C_POST, C_TRAIL, C_EXIT
   } state_t;

   localparam logic [8*LANES-1:0] SYNC = {LANES{8'hB8}};

   state_t             state, state_nx;
   logic [7:0]         cnt, cnt_nx;
   logic               done, accept;
   logic [LANES-1:0]   last_b7, b7_nx;
   logic [8*LANES-1:0] trail, d_out;
   logic               c_p, c_n, c_oe, c_hs, c_run;
   logic               d_p, d_n, d_oe, d_hs, ur_nx;

   function automatic logic [7:0] dur(input state_t st);
      case (st)
         C_LP01, D_LP01:          dur = 8'(T_LPX);
         C_LP00, D_LP00:          dur = 8'(T_PREP);
         C_ZERO, D_ZERO, C_TRAIL: dur = 8'(T_ZERO);
         C_PRE:                   dur = 8'(T_CLK_PRE);
         D_TRAIL:                 dur = 8'(T_TRAIL);
         C_POST:                  dur = 8'(T_CLK_POST);
         default:                 dur = 8'd1;
      endcase
   endfunction

   assign done      = (cnt == 8'd0);
   assign accept    = (state == PAYLOAD) && s.s_valid;
   assign s.s_ready = (state == PAYLOAD);
   assign busy      = (state != IDLE);

   // Trailer drives the inverse of the last serialised bit on each lane
   always_comb begin
      trail = '0;
      b7_nx = last_b7;
      for (int k = 0; k < LANES; k++) begin
         trail[8*k +: 8] = {8{~last_b7[k]}};
         if (accept) b7_nx[k] = s.s_data[8*k+7];
      end
      if (state == D_SYNC) b7_nx = '1;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (s.s_valid) state_nx = C_LP01;
         C_LP01:  if (done) state_nx = C_LP00;
         C_LP00:  if (done) state_nx = C_ZERO;
         C_ZERO:  if (done) state_nx = C_PRE;
         C_PRE:   if (done) state_nx = D_LP01;
         D_LP01:  if (done) state_nx = D_LP00;
         D_LP00:  if (done) state_nx = D_ZERO;
         D_ZERO:  if (done) state_nx = D_SYNC;
         D_SYNC:  if (done) state_nx = PAYLOAD;
         PAYLOAD: if (!s.s_valid || s.s_last) state_nx = D_TRAIL;
         D_TRAIL: if (done) state_nx = D_EXIT;
         D_EXIT:  if (done) state_nx = C_POST;
         C_POST:  if (done) state_nx = C_TRAIL;
         C_TRAIL: if (done) state_nx = C_EXIT;
         C_EXIT:  if (done) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
      cnt_nx = done ? 8'd0 : cnt - 8'd1;
      if (state_nx != state) cnt_nx = dur(state_nx) - 8'd1;
   end

   always_comb begin
      c_p = 1'b1; c_n = 1'b1; c_oe = 1'b1; c_hs = 1'b0; c_run = 1'b0;
      d_p = 1'b1; d_n = 1'b1; d_oe = 1'b1; d_hs = 1'b0; d_out = '0;
      ur_nx = (state == PAYLOAD) && !s.s_valid;
      case (state)
         C_LP01: c_p = 1'b0;
         C_LP00: begin c_p = 1'b0; c_n = 1'b0; end
         C_ZERO, C_TRAIL: begin
            c_p = 1'b0; c_n = 1'b0; c_oe = 1'b0; c_hs = 1'b1;
         end
         C_PRE, D_LP01, D_LP00, D_ZERO, D_SYNC,
         PAYLOAD, D_TRAIL, D_EXIT, C_POST: begin
            c_p = 1'b0; c_n = 1'b0; c_oe = 1'b0;
            c_hs = 1'b1; c_run = 1'b1;
         end
         default: ;
      endcase
      case (state)
         D_LP01: d_p = 1'b0;
         D_LP00: begin d_p = 1'b0; d_n = 1'b0; end
         D_ZERO, D_SYNC, PAYLOAD, D_TRAIL: begin
            d_p = 1'b0; d_n = 1'b0; d_oe = 1'b0; d_hs = 1'b1;
         end
         default: ;
      endcase
      case (state)
         D_SYNC:  d_out = SYNC;
         PAYLOAD: d_out = accept ? s.s_data : trail;
         D_TRAIL: d_out = trail;
         default: d_out = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         cnt          <= 8'd0;
         last_b7      <= '1;
         underrun     <= 1'b0;
         clk_lp_p_out <= 1'b1;
         clk_lp_n_out <= 1'b1;
         clk_lp_oe    <= 1'b1;
         clk_hs_oe    <= 1'b0;
         clk_hs_run   <= 1'b0;
         d_hs_out     <= '0;
         d_hs_oe      <= 1'b0;
         d_lp_p_out   <= '1;
         d_lp_n_out   <= '1;
         d_lp_oe      <= '1;
      end else begin
         state        <= state_nx;
         cnt          <= cnt_nx;
         last_b7      <= b7_nx;
         underrun     <= ur_nx;
         clk_lp_p_out <= c_p;
         clk_lp_n_out <= c_n;
         clk_lp_oe    <= c_oe;
         clk_hs_oe    <= c_hs;
         clk_hs_run   <= c_run;
         d_hs_out     <= d_out;
         d_hs_oe      <= d_hs;
         d_lp_p_out   <= {LANES{d_p}};
         d_lp_n_out   <= {LANES{d_n}};
         d_lp_oe      <= {LANES{d_oe}};
      end
   end
endmodule

// File: tb/tb_mipi_dphy_tx_burst_seq.sv
// Directed bench for the D-PHY TX burst sequencer (LANES=4, default timing).
// Expected values are hand-derived from the burst sequence.
module tb_mipi_dphy_tx_burst_seq;
   localparam int L = 4;
   localparam int LAT = 42;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mipi_dphy_tx_burst_seq_if #(.LANES(L)) sif ();

   logic          busy, underrun;
   logic          clk_lp_p_out, clk_lp_n_out, clk_lp_oe;
   logic          clk_hs_oe, clk_hs_run;
   logic [8*L-1:0] d_hs_out;
   logic          d_hs_oe;
   logic [L-1:0]  d_lp_p_out, d_lp_n_out, d_lp_oe;

   mipi_dphy_tx_burst_seq #(.LANES(L)) dut (
      .clk(clk), .rst(rst), .s(sif),
      .busy(busy), .underrun(underrun),
      .clk_lp_p_out(clk_lp_p_out), .clk_lp_n_out(clk_lp_n_out),
      .clk_lp_oe(clk_lp_oe), .clk_hs_oe(clk_hs_oe),
      .clk_hs_run(clk_hs_run), .d_hs_out(d_hs_out),
      .d_hs_oe(d_hs_oe), .d_lp_p_out(d_lp_p_out),
      .d_lp_n_out(d_lp_n_out), .d_lp_oe(d_lp_oe)
   );

   int npass = 0;
   int ntot  = 0;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic all_lp11();
      return clk_lp_p_out && clk_lp_n_out && clk_lp_oe &&
             (d_lp_p_out == '1) && (d_lp_n_out == '1) &&
             (d_lp_oe == '1) && !clk_hs_oe && !d_hs_oe;
   endfunction

   // Steps from the IDLE sampling edge until s_ready; lat=0 on timeout
   task automatic wait_ready(output int lat, output int c01, output int c00,
                             output int cz, output int cpre, output int d01,
                             output int d00, output int dz);
      lat = 0; c01 = 0; c00 = 0; cz = 0; cpre = 0; d01 = 0; d00 = 0; dz = 0;
      for (int i = 1; i <= 200; i++) begin
         step();
         if (clk_lp_oe && !clk_lp_p_out && clk_lp_n_out) c01++;
         if (clk_lp_oe && !clk_lp_p_out && !clk_lp_n_out) c00++;
         if (clk_hs_oe && !clk_hs_run && !d_hs_oe) cz++;
         if (clk_hs_run && d_lp_oe == '1 && d_lp_p_out == '1 &&
             d_lp_n_out == '1) cpre++;
         if (d_lp_oe == '1 && d_lp_p_out == '0 && d_lp_n_out == '1) d01++;
         if (d_lp_oe == '1 && d_lp_p_out == '0 && d_lp_n_out == '0) d00++;
         if (d_hs_oe && d_lp_oe == '0 && d_hs_out == '0) dz++;
         if (sif.s_ready) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic wait_idle(output int n);
      n = -1;
      for (int i = 1; i <= 100; i++) begin
         step();
         if (!busy) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic test_reset();
      logic ok;
      sif.s_valid = 1'b0; sif.s_last = 1'b0; sif.s_data = '0;
      rst = 1'b1;
      step(); step();
      rst = 1'b0;
      ok = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step();
         if (!all_lp11() || busy || sif.s_ready || underrun) ok = 1'b0;
      end
      ntot++; if (ok !== 1'b1) $display("FAIL reset_idle20: got %b want 1", ok); else npass++;
      ntot++; if (d_lp_p_out !== 4'hF) $display("FAIL reset_d_lp_p: got %h want f", d_lp_p_out); else npass++;
      ntot++; if (d_lp_oe !== 4'hF) $display("FAIL reset_d_lp_oe: got %h want f", d_lp_oe); else npass++;
      ntot++; if (clk_hs_oe !== 1'b0) $display("FAIL reset_clk_hs_oe: got %b want 0", clk_hs_oe); else npass++;
      ntot++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else npass++;
      ntot++; if (sif.s_ready !== 1'b0) $display("FAIL reset_s_ready: got %b want 0", sif.s_ready); else npass++;
      ntot++; if (d_hs_out !== 32'h0) $display("FAIL reset_d_hs_out: got %h want 0", d_hs_out); else npass++;
   endtask

   task automatic test_single_burst();
      int lat, c01, c00, cz, cpre, d01, d00, dz, tc, n;
      sif.s_valid = 1'b1; sif.s_last = 1'b0; sif.s_data = 32'h03020100;
      wait_ready(lat, c01, c00, cz, cpre, d01, d00, dz);
      ntot++; if (lat !== LAT) $display("FAIL single_latency: got %0d want %0d", lat, LAT); else npass++;
      ntot++; if (c01 !== 4) $display("FAIL clk_lp01_len: got %0d want 4", c01); else npass++;
      ntot++; if (c00 !== 4) $display("FAIL clk_lp00_len: got %0d want 4", c00); else npass++;
      ntot++; if (cz !== 10) $display("FAIL clk_zero_len: got %0d want 10", cz); else npass++;
      ntot++; if (cpre !== 4) $display("FAIL clk_pre_len: got %0d want 4", cpre); else npass++;
      ntot++; if (d01 !== 4) $display("FAIL d_lp01_len: got %0d want 4", d01); else npass++;
      ntot++; if (d00 !== 4) $display("FAIL d_lp00_len: got %0d want 4", d00); else npass++;
      ntot++; if (dz !== 10) $display("FAIL d_zero_len: got %0d want 10", dz); else npass++;
      ntot++; if (d_hs_out !== 32'hB8B8B8B8) $display("FAIL single_sync: got %h want b8b8b8b8", d_hs_out); else npass++;
      step();
      ntot++; if (d_hs_out !== 32'h03020100) $display("FAIL single_beat0: got %h want 03020100", d_hs_out); else npass++;
      sif.s_data = 32'h07060504;
      step();
      ntot++; if (d_hs_out !== 32'h07060504) $display("FAIL single_beat1: got %h want 07060504", d_hs_out); else npass++;
      sif.s_data = 32'h8B8A8988; sif.s_last = 1'b1;
      step();
      ntot++; if (d_hs_out !== 32'h8B8A8988) $display("FAIL single_beat2: got %h want 8b8a8988", d_hs_out); else npass++;
      sif.s_valid = 1'b0; sif.s_last = 1'b0;
      tc = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (d_hs_oe && d_hs_out == 32'h0) tc++;
         else break;
      end
      ntot++; if (tc !== 6) $display("FAIL single_trail_len: got %0d want 6", tc); else npass++;
      ntot++; if (d_lp_p_out !== 4'hF || d_lp_oe !== 4'hF) $display("FAIL single_d_exit: got p=%h oe=%h want f f", d_lp_p_out, d_lp_oe); else npass++;
      wait_idle(n);
      ntot++; if ((n > 0) !== 1'b1) $display("FAIL single_idle: got %0d want >0", n); else npass++;
      ntot++; if (all_lp11() !== 1'b1) $display("FAIL single_lp11: got %b want 1", all_lp11()); else npass++;
   endtask

   task automatic test_trailer_polarity();
      int lat, c01, c00, cz, cpre, d01, d00, dz, tc, n;
      sif.s_valid = 1'b1; sif.s_last = 1'b1; sif.s_data = 32'h7F80FF00;
      wait_ready(lat, c01, c00, cz, cpre, d01, d00, dz);
      ntot++; if (lat !== LAT) $display("FAIL pol_latency: got %0d want %0d", lat, LAT); else npass++;
      step();
      ntot++; if (d_hs_out !== 32'h7F80FF00) $display("FAIL pol_beat: got %h want 7f80ff00", d_hs_out); else npass++;
      sif.s_valid = 1'b0; sif.s_last = 1'b0;
      tc = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (d_hs_oe && d_hs_out == 32'hFF0000FF) tc++;
         else break;
      end
      ntot++; if (tc !== 6) $display("FAIL pol_trail: got %0d cycles of ff0000ff want 6", tc); else npass++;
      wait_idle(n);
      ntot++; if (all_lp11() !== 1'b1) $display("FAIL pol_lp11: got %b want 1", all_lp11()); else npass++;
   endtask

   task automatic test_underrun();
      int lat, c01, c00, cz, cpre, d01, d00, dz, n;
      sif.s_valid = 1'b1; sif.s_last = 1'b0; sif.s_data = 32'h11223344;
      wait_ready(lat, c01, c00, cz, cpre, d01, d00, dz);
      ntot++; if (lat !== LAT) $display("FAIL ur_latency: got %0d want %0d", lat, LAT); else npass++;
      step();
      ntot++; if (d_hs_out !== 32'h11223344) $display("FAIL ur_beat1: got %h want 11223344", d_hs_out); else npass++;
      sif.s_data = 32'h807F00FF;
      step();
      ntot++; if (d_hs_out !== 32'h807F00FF) $display("FAIL ur_beat2: got %h want 807f00ff", d_hs_out); else npass++;
      ntot++; if (underrun !== 1'b0) $display("FAIL ur_early: got %b want 0", underrun); else npass++;
      sif.s_valid = 1'b0;
      step();
      ntot++; if (underrun !== 1'b1) $display("FAIL ur_pulse: got %b want 1", underrun); else npass++;
      ntot++; if (d_hs_out !== 32'h00FFFF00) $display("FAIL ur_trail: got %h want 00ffff00", d_hs_out); else npass++;
      step();
      ntot++; if (underrun !== 1'b0) $display("FAIL ur_width: got %b want 0", underrun); else npass++;
      wait_idle(n);
      ntot++; if (all_lp11() !== 1'b1) $display("FAIL ur_lp11: got %b want 1", all_lp11()); else npass++;
   endtask

   task automatic test_reset_mid();
      int lat, c01, c00, cz, cpre, d01, d00, dz, n;
      sif.s_valid = 1'b1; sif.s_last = 1'b0; sif.s_data = 32'hA0A0A0A0;
      wait_ready(lat, c01, c00, cz, cpre, d01, d00, dz);
      for (int k = 1; k <= 4; k++) begin
         step();
         sif.s_data = 32'hA0A0A0A0 + 32'(k);
      end
      rst = 1'b1;
      step();
      rst = 1'b0; sif.s_valid = 1'b0;
      ntot++; if (all_lp11() !== 1'b1) $display("FAIL rst_lp11: got %b want 1", all_lp11()); else npass++;
      ntot++; if (d_hs_oe !== 1'b0) $display("FAIL rst_d_hs_oe: got %b want 0", d_hs_oe); else npass++;
      ntot++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else npass++;
      ntot++; if (d_hs_out !== 32'h0) $display("FAIL rst_d_hs_out: got %h want 0", d_hs_out); else npass++;
      step();
      sif.s_valid = 1'b1; sif.s_last = 1'b1; sif.s_data = 32'h03020100;
      wait_ready(lat, c01, c00, cz, cpre, d01, d00, dz);
      ntot++; if (lat !== LAT) $display("FAIL rst_relatency: got %0d want %0d", lat, LAT); else npass++;
      ntot++; if (d_hs_out !== 32'hB8B8B8B8) $display("FAIL rst_resync: got %h want b8b8b8b8", d_hs_out); else npass++;
      step();
      ntot++; if (d_hs_out !== 32'h03020100) $display("FAIL rst_rebeat: got %h want 03020100", d_hs_out); else npass++;
      sif.s_valid = 1'b0; sif.s_last = 1'b0;
      wait_idle(n);
      ntot++; if (all_lp11() !== 1'b1) $display("FAIL rst_relp11: got %b want 1", all_lp11()); else npass++;
   endtask

   task automatic test_back_to_back();
      int lat, c01, c00, cz, cpre, d01, d00, dz, n;
      sif.s_valid = 1'b1; sif.s_last = 1'b1; sif.s_data = 32'h55AA55AA;
      wait_ready(lat, c01, c00, cz, cpre, d01, d00, dz);
      ntot++; if (lat !== LAT) $display("FAIL b2b_lat1: got %0d want %0d", lat, LAT); else npass++;
      step();
      wait_idle(n);
      ntot++; if ((n > 0) !== 1'b1) $display("FAIL b2b_idle: got %0d want >0", n); else npass++;
      ntot++; if (all_lp11() !== 1'b1) $display("FAIL b2b_idle_lp11: got %b want 1", all_lp11()); else npass++;
      wait_ready(lat, c01, c00, cz, cpre, d01, d00, dz);
      ntot++; if (lat !== LAT) $display("FAIL b2b_lat2: got %0d want %0d", lat, LAT); else npass++;
      ntot++; if (c01 !== 4) $display("FAIL b2b_clk_lp01: got %0d want 4", c01); else npass++;
      ntot++; if (c00 !== 4) $display("FAIL b2b_clk_lp00: got %0d want 4", c00); else npass++;
      ntot++; if (d01 !== 4) $display("FAIL b2b_d_lp01: got %0d want 4", d01); else npass++;
      ntot++; if (d00 !== 4) $display("FAIL b2b_d_lp00: got %0d want 4", d00); else npass++;
      step();
      sif.s_valid = 1'b0; sif.s_last = 1'b0;
      wait_idle(n);
      ntot++; if (all_lp11() !== 1'b1) $display("FAIL b2b_end_lp11: got %b want 1", all_lp11()); else npass++;
   endtask

   initial begin
      rst = 1'b1;
      sif.s_valid = 1'b0; sif.s_last = 1'b0; sif.s_data = '0;
      test_reset();
      test_single_burst();
      test_trailer_polarity();
      test_underrun();
      test_reset_mid();
      test_back_to_back();
      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end
endmodule
